// File: rtl/mrcs_sweep_sequencer_pkg.sv
// Shared types and default widths for the exhaustive sweep sequencer.
package mrcs_sweep_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_IN_W   = 2;
  localparam int unsigned DEF_OUT_W  = 2;
  localparam int unsigned DEF_SETTLE = 1;
  localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/mrcs_sweep_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module mrcs_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mrcs_sweep_sequencer.sv
// Exhaustive sweep of a combinational CUT: drive each vector, settle, fetch the
// expected value from a truth-table ROM, compare and count mismatches.
module mrcs_sweep_sequencer
  import mrcs_sweep_sequencer_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             exp_req,
  output logic [IN_W-1:0]  exp_addr,
  input  logic             exp_valid,
  input  logic [OUT_W-1:0] exp_data,
  output logic             mism_valid,
  output logic [IN_W-1:0]  mism_vec,
  output logic [OUT_W-1:0] mism_got,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TW = $clog2(SETTLE + 1);
  localparam logic [IN_W:0] LAST_VEC = {1'b0, {IN_W{1'b1}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IN_W:0]     r_vec;
  logic [TW-1:0]     r_timer;
  logic [IN_W-1:0]   r_dut_in;
  logic              r_done;
  logic              r_pass;
  logic              r_mism_valid;
  logic [IN_W-1:0]   r_mism_vec;
  logic [OUT_W-1:0]  r_mism_got;
  logic              w_start_ok;
  logic              w_compare;
  logic              w_mismatch;
  logic              w_abort_act;
  logic              w_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes; abort pre-empts any compare.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_compare   = 1'b0;
    w_abort_act = 1'b0;
    w_last      = (r_vec == LAST_VEC);
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_start_ok  = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          w_abort_act = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_abort_act = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == TW'(1)) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          w_abort_act = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (exp_valid) begin
          w_compare   = 1'b1;
          w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_mismatch = w_compare && (dut_out != exp_data);

  // Vector counter, settle timer and the registered CUT drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec    <= '0;
      r_timer  <= '0;
      r_dut_in <= '0;
    end else begin
      if (w_start_ok) begin
        r_vec <= '0;
      end else if (w_compare && !w_last) begin
        r_vec <= r_vec + 1'b1;
      end
      if (r_state == ST_DRIVE) begin
        r_timer  <= TW'(SETTLE);
        r_dut_in <= r_vec[IN_W-1:0];
      end else if (r_state == ST_WAIT) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  // Mismatch capture, completion pulse and pass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mism_valid <= 1'b0;
      r_mism_vec   <= '0;
      r_mism_got   <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_mism_valid <= w_mismatch;
      if (w_start_ok) begin
        r_mism_vec <= '0;
        r_mism_got <= '0;
      end else if (w_mismatch) begin
        r_mism_vec <= r_vec[IN_W-1:0];
        r_mism_got <= dut_out;
      end
      r_done <= (r_state == ST_DONE);
      if (w_start_ok || w_abort_act) begin
        r_pass <= 1'b0;
      end else if (r_state == ST_DONE) begin
        r_pass <= (err_count == '0);
      end
    end
  end

  mrcs_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start_ok),
    .inc   (w_mismatch),
    .count (err_count)
  );

  assign busy       = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_FETCH);
  assign exp_req    = (r_state == ST_FETCH);
  assign exp_addr   = r_vec[IN_W-1:0];
  assign dut_in     = r_dut_in;
  assign done       = r_done;
  assign pass       = r_pass;
  assign mism_valid = r_mism_valid;
  assign mism_vec   = r_mism_vec;
  assign mism_got   = r_mism_got;

endmodule

// File: tb/tb_mrcs_sweep_sequencer.sv
// Bench for the sweep sequencer: inverter-on-bit0 CUT, ROM with programmable
// latency, two instances (CNT_W=8 and CNT_W=2) run in lockstep.
`timescale 1ns/1ps
module tb_mrcs_sweep_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  logic       busy_a, done_a, pass_a, exp_req_a, mism_valid_a;
  logic [1:0] dut_in_a, dut_out_a, exp_addr_a, exp_data_a, mism_vec_a, mism_got_a;
  logic [7:0] err_a;
  logic       busy_b, done_b, pass_b, exp_req_b, mism_valid_b;
  logic [1:0] dut_in_b, dut_out_b, exp_addr_b, exp_data_b, mism_vec_b, mism_got_b;
  logic [1:0] err_b;
  logic       exp_valid;

  logic [1:0] rom [4];
  int lat;
  int wcnt;
  int checks = 0;
  int failures = 0;
  int done_at, ndone, reqc, nb;
  logic [3:0] mq[$];
  logic busy_h [0:255];
  logic req_h  [0:255];

  function automatic logic [1:0] cut(input logic [1:0] v);
    return {v[1], ~v[0]};
  endfunction

  assign dut_out_a  = cut(dut_in_a);
  assign dut_out_b  = cut(dut_in_b);
  assign exp_data_a = rom[exp_addr_a];
  assign exp_data_b = rom[exp_addr_b];
  assign exp_valid  = exp_req_a && (wcnt >= lat);

  // ROM latency model: valid after lat cycles of a held request.
  always @(posedge clk) begin
    if (rst || !exp_req_a || exp_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  mrcs_sweep_sequencer #(.IN_W(2), .OUT_W(2), .SETTLE(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_a), .done(done_a),
    .pass(pass_a), .dut_in(dut_in_a), .dut_out(dut_out_a), .exp_req(exp_req_a),
    .exp_addr(exp_addr_a), .exp_valid(exp_valid), .exp_data(exp_data_a),
    .mism_valid(mism_valid_a), .mism_vec(mism_vec_a), .mism_got(mism_got_a), .err_count(err_a));

  mrcs_sweep_sequencer #(.IN_W(2), .OUT_W(2), .SETTLE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_b), .done(done_b),
    .pass(pass_b), .dut_in(dut_in_b), .dut_out(dut_out_b), .exp_req(exp_req_b),
    .exp_addr(exp_addr_b), .exp_valid(exp_valid), .exp_data(exp_data_b),
    .mism_valid(mism_valid_b), .mism_vec(mism_vec_b), .mism_got(mism_got_b), .err_count(err_b));

  task automatic rom_correct();
    for (int v = 0; v < 4; v++) rom[v] = cut(2'(v));
  endtask

  // One sweep: start is sampled on the first edge; k counts edges after it.
  task automatic sweep(input int budget, input int spur_start, input int abort_at);
    mq.delete();
    nb = 0; ndone = 0; reqc = 0; done_at = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      busy_h[k] = busy_a;
      req_h[k]  = exp_req_a;
      if (exp_req_a) reqc++;
      if (mism_valid_a) mq.push_back({mism_vec_a, mism_got_a});
      if (mism_valid_b) nb++;
      if (done_a) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (k == spur_start) start = 1'b1;
      if (k == abort_at) abort = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rom_correct(); lat = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, dut_in_a, exp_req_a, exp_addr_a, mism_valid_a, mism_vec_a, mism_got_a, err_a} !== '0) begin
      failures++;
      $display("FAIL reset_outs_a got=%h want=0", {busy_a, done_a, pass_a, dut_in_a, exp_req_a, exp_addr_a, mism_valid_a, mism_vec_a, mism_got_a, err_a});
    end
    checks++;
    if ({busy_b, done_b, pass_b, mism_valid_b, err_b} !== '0) begin
      failures++;
      $display("FAIL reset_outs_b got=%h want=0", {busy_b, done_b, pass_b, mism_valid_b, err_b});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    rom_correct(); lat = 0;
    sweep(20, -1, -1);
    checks++;
    if (done_at !== 13 || ndone !== 1) begin
      failures++; $display("FAIL pass_done_timing got=%0d/%0d want=13/1", done_at, ndone);
    end
    checks++;
    if (pass_a !== 1'b1 || err_a !== 8'd0 || mq.size() != 0) begin
      failures++; $display("FAIL pass_result got pass=%b err=%0d mism=%0d want 1/0/0", pass_a, err_a, mq.size());
    end
    checks++;
    if (reqc !== 4 || busy_h[1] !== 1'b1 || busy_h[12] !== 1'b0 || busy_h[13] !== 1'b0) begin
      failures++; $display("FAIL pass_busy_req got req=%0d busy1=%b busy12=%b", reqc, busy_h[1], busy_h[12]);
    end
    checks++;
    if (dut_in_a !== 2'd3) begin
      failures++; $display("FAIL dut_in_hold got=%0d want=3", dut_in_a);
    end
  endtask

  task automatic test_single_mismatch();
    rom_correct(); rom[2] = 2'b10; lat = 0;
    sweep(20, -1, -1);
    checks++;
    if (mq.size() != 1 || (mq.size() == 1 && mq[0] !== 4'b1011)) begin
      failures++; $display("FAIL single_mism got n=%0d first=%b want n=1 vec=2 got=11", mq.size(), (mq.size() > 0) ? mq[0] : 4'hx);
    end
    checks++;
    if (err_a !== 8'd1 || pass_a !== 1'b0 || done_at !== 13) begin
      failures++; $display("FAIL single_result got err=%0d pass=%b done=%0d want 1/0/13", err_a, pass_a, done_at);
    end
    checks++;
    if (mism_vec_a !== 2'd2 || mism_got_a !== 2'b11) begin
      failures++; $display("FAIL mism_hold got vec=%0d got=%b want 2/11", mism_vec_a, mism_got_a);
    end
  endtask

  task automatic test_latency();
    rom_correct(); lat = 3;
    sweep(32, -1, -1);
    checks++;
    if (done_at !== 25 || ndone !== 1 || pass_a !== 1'b1) begin
      failures++; $display("FAIL latency_done got=%0d n=%0d pass=%b want 25/1/1", done_at, ndone, pass_a);
    end
    checks++;
    if (reqc !== 16) begin
      failures++; $display("FAIL latency_req_hold got=%0d want=16", reqc);
    end
  endtask

  task automatic test_saturate();
    for (int v = 0; v < 4; v++) rom[v] = ~cut(2'(v));
    lat = 0;
    sweep(20, -1, -1);
    checks++;
    if (nb !== 4 || err_b !== 2'd3 || pass_b !== 1'b0) begin
      failures++; $display("FAIL saturate got pulses=%0d err=%0d pass=%b want 4/3/0", nb, err_b, pass_b);
    end
    checks++;
    if (err_a !== 8'd4) begin
      failures++; $display("FAIL wide_count got=%0d want=4", err_a);
    end
  endtask

  task automatic test_abort();
    rom_correct(); lat = 0;
    sweep(24, -1, 4);
    checks++;
    if (busy_h[4] !== 1'b1 || busy_h[5] !== 1'b0 || req_h[5] !== 1'b0) begin
      failures++; $display("FAIL abort_wait got busy4=%b busy5=%b req5=%b want 1/0/0", busy_h[4], busy_h[5], req_h[5]);
    end
    checks++;
    if (ndone !== 0 || pass_a !== 1'b0) begin
      failures++; $display("FAIL abort_nodone got done=%0d pass=%b want 0/0", ndone, pass_a);
    end
    sweep(20, -1, -1);
    checks++;
    if (done_at !== 13 || pass_a !== 1'b1) begin
      failures++; $display("FAIL abort_restart got done=%0d pass=%b want 13/1", done_at, pass_a);
    end
    // abort raised while in DONE must not suppress the pulse
    sweep(20, -1, 12);
    checks++;
    if (done_at !== 13 || ndone !== 1) begin
      failures++; $display("FAIL abort_in_done got=%0d n=%0d want 13/1", done_at, ndone);
    end
    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL start_abort_idle got busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int got_req;
    rom_correct(); lat = 0;
    sweep(24, 6, -1);
    checks++;
    if (done_at !== 13 || ndone !== 1) begin
      failures++; $display("FAIL start_while_busy got=%0d n=%0d want 13/1", done_at, ndone);
    end
    rom_correct(); rom[1] = 2'b00; lat = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_req = 0;
    for (int k = 0; k < 60; k++) begin
      if (exp_req_a && exp_addr_a == 2'd3) begin
        got_req = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got_req != 1) begin
      failures++; $display("FAIL rst_reach_fetch got=%0d want=1", got_req);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_a, done_a, pass_a, dut_in_a, exp_req_a, exp_addr_a, mism_valid_a, mism_vec_a, mism_got_a, err_a} !== '0) begin
      failures++; $display("FAIL rst_in_fetch got=%h want=0", {busy_a, done_a, pass_a, dut_in_a, exp_req_a, exp_addr_a, mism_valid_a, mism_vec_a, mism_got_a, err_a});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int nm, want_done;
    logic [3:0] want[$];
    for (int it = 0; it < 8; it++) begin
      want.delete();
      for (int v = 0; v < 4; v++)
        rom[v] = ($urandom_range(0, 1) == 1) ? cut(2'(v)) : 2'($urandom_range(0, 3));
      lat = $urandom_range(0, 3);
      for (int v = 0; v < 4; v++)
        if (rom[v] != cut(2'(v))) want.push_back({2'(v), cut(2'(v))});
      nm = want.size();
      want_done = 4 * (1 + 2 + lat) + 1;
      sweep(want_done + 6, -1, -1);
      checks++;
      if (done_at !== want_done || ndone !== 1) begin
        failures++; $display("FAIL rand%0d_done got=%0d n=%0d want %0d/1", it, done_at, ndone, want_done);
      end
      checks++;
      if (mq.size() != nm || mq != want) begin
        failures++; $display("FAIL rand%0d_mism_list got n=%0d want n=%0d", it, mq.size(), nm);
      end
      checks++;
      if (err_a !== 8'(nm) || err_b !== 2'((nm > 3) ? 3 : nm) || pass_a !== (nm == 0) || pass_b !== (nm == 0)) begin
        failures++; $display("FAIL rand%0d_counts got err=%0d/%0d pass=%b want %0d pass=%b", it, err_a, err_b, pass_a, nm, (nm == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_single_mismatch();
    test_latency();
    test_saturate();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
